pc_select_reg: RTL and testbench

Parametrised program-counter source unit for the multicycle MIPS datapath. It combines the PC source multiplexer and the PC register, and adds a built-in exception sequencer. The sequencer saves the EPC, fetches the handler address byte from the exception vector area in memory, and redirects the PC. It sits between the ALU/branch/jump/EPC/sign-extend/memory paths and the instruction-address input of memory, driven by the control unit.

---
 rtl/pc_select_reg_pkg.sv | 17 +
 rtl/pc_select_reg_if.sv | 41 ++++
 rtl/pc_select_reg_pc_src_mux.sv | 24 ++
 rtl/pc_select_reg.sv | 123 ++++++++++++
 tb/tb_pc_select_reg.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pc_select_reg_pkg.sv
// Shared types and constants for the PC source/exception unit.
package pc_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        FETCH = 2'd2
    } pc_state_e;

    localparam logic [1:0] EXC_OPCODE = 2'd0;
    localparam logic [1:0] EXC_OVF    = 2'd1;
    localparam logic [1:0] EXC_DIV0   = 2'd2;
    localparam logic [1:0] EXC_ALIGN  = 2'd3;

    localparam int DEF_VEC_BASE = 253;

endpackage

// File: rtl/pc_select_reg_if.sv
// Control/datapath bundle for pc_select_reg.
// The align_err signal exists only when PC_SEL_ALIGN_CHECK_EN is defined.
interface pc_select_reg_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
);
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     pc_load;
    logic                     exc_req;
    logic [1:0]               exc_code;
    logic                     busy;
    logic [WIDTH-1:0]         pc_out;
    logic [WIDTH-1:0]         epc_out;
    logic                     sel_err;
    logic                     vec_req;
    logic [WIDTH-1:0]         vec_addr;
    logic                     vec_ack;
    logic [7:0]               vec_data;
`ifdef PC_SEL_ALIGN_CHECK_EN
    logic                     align_err;
`endif

    modport master (
        output sel, src_data, pc_load, exc_req, exc_code, vec_ack, vec_data,
        input  busy, pc_out, epc_out, sel_err, vec_req, vec_addr
`ifdef PC_SEL_ALIGN_CHECK_EN
        , input align_err
`endif
    );

    modport slave (
        input  sel, src_data, pc_load, exc_req, exc_code, vec_ack, vec_data,
        output busy, pc_out, epc_out, sel_err, vec_req, vec_addr
`ifdef PC_SEL_ALIGN_CHECK_EN
        , output align_err
`endif
    );

endinterface

// File: rtl/pc_select_reg_pc_src_mux.sv
// Combinational NUM_SRC-to-1 selector; out-of-range selects yield zero and sel_valid_o low.
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NUM_SRC*WIDTH-1:0] src_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     sel_valid_o
);

    always_comb begin
        data_o      = '0;
        sel_valid_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_i == SEL_W'(i)) begin
                data_o      = src_i[i*WIDTH +: WIDTH];
                sel_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_select_reg.sv
// PC source mux + PC/EPC registers + exception vector sequencer (IDLE/SAVE/FETCH).
// Define PC_SEL_ALIGN_CHECK_EN to reject misaligned loads and raise a code-3 exception.
module pc_select_reg
    import pc_sel_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 6,
    parameter int SEL_W      = 3,
    parameter int RESET_PC   = 0,
    parameter int EPC_OFFSET = 4,
    parameter int VEC_BASE   = DEF_VEC_BASE
) (
    input  logic              clk,
    input  logic              reset,
    pc_select_reg_if.slave    bus
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       code_q, code_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] mux_data;
    logic             sel_valid;
    logic             take_exc;
`ifdef PC_SEL_ALIGN_CHECK_EN
    logic             align_err_q, align_err_d;
    logic             align_exc_q, align_exc_d;
`endif

    pc_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux (
        .sel_i       (bus.sel),
        .src_i       (bus.src_data),
        .data_o      (mux_data),
        .sel_valid_o (sel_valid)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        code_d    = code_q;
        sel_err_d = 1'b0;
        take_exc  = bus.exc_req;
`ifdef PC_SEL_ALIGN_CHECK_EN
        align_err_d = 1'b0;
        align_exc_d = align_exc_q;
        // A rejected misaligned load becomes an exception on the following cycle
        take_exc    = bus.exc_req | align_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (take_exc) begin
                    state_d = SAVE;
`ifdef PC_SEL_ALIGN_CHECK_EN
                    align_exc_d = align_err_q;
`endif
                end else if (bus.pc_load) begin
                    if (!sel_valid) begin
                        sel_err_d = 1'b1;
`ifdef PC_SEL_ALIGN_CHECK_EN
                    end else if (mux_data[1:0] != 2'b00) begin
                        align_err_d = 1'b1;
`endif
                    end else begin
                        pc_d = mux_data;
                    end
                end
            end
            SAVE: begin
                epc_d   = pc_q - WIDTH'(EPC_OFFSET);
`ifdef PC_SEL_ALIGN_CHECK_EN
                code_d  = align_exc_q ? EXC_ALIGN : bus.exc_code;
`else
                code_d  = bus.exc_code;
`endif
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.vec_ack) begin
                    pc_d    = WIDTH'(bus.vec_data);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= WIDTH'(RESET_PC);
            epc_q     <= '0;
            code_q    <= '0;
            sel_err_q <= 1'b0;
`ifdef PC_SEL_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
            align_exc_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            code_q    <= code_d;
            sel_err_q <= sel_err_d;
`ifdef PC_SEL_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
            align_exc_q <= align_exc_d;
`endif
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.epc_out  = epc_q;
    assign bus.sel_err  = sel_err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.vec_req  = (state_q == FETCH);
    assign bus.vec_addr = (state_q == FETCH) ? (WIDTH'(VEC_BASE) + WIDTH'(code_q)) : '0;
`ifdef PC_SEL_ALIGN_CHECK_EN
    assign bus.align_err = align_err_q;
`endif

endmodule

// File: tb/tb_pc_select_reg.sv
// Directed bench for pc_select_reg: loads, sel_err, exception sequencing, reset, alignment option.
module tb_pc_select_reg;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_select_reg_if #(.WIDTH(32), .NUM_SRC(6), .SEL_W(3)) bus ();

    pc_select_reg #(
        .WIDTH(32), .NUM_SRC(6), .SEL_W(3), .RESET_PC(0), .EPC_OFFSET(4), .VEC_BASE(253)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] v);
        bus.src_data[i*32 +: 32] = v;
    endtask

    task automatic load(input logic [2:0] s);
        bus.sel = s; bus.pc_load = 1'b1;
        tick();
        bus.pc_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sel = '0; bus.pc_load = 0; bus.exc_req = 0; bus.exc_code = 0;
        bus.vec_ack = 0; bus.vec_data = 0;
        for (int i = 0; i < 6; i++) set_src(i, 32'h1000 + 32'(4*i));
        #3;
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", bus.pc_out, 32'h0); end
        checks++; if (bus.epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h exp %h", bus.epc_out, 32'h0); end
        checks++; if ({bus.busy, bus.vec_req, bus.sel_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {bus.busy, bus.vec_req, bus.sel_err}); end
        checks++; if (bus.vec_addr !== 32'h0) begin errors++; $display("FAIL reset_vec_addr: got %h exp 0", bus.vec_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            load(3'(i));
            checks++; if (bus.pc_out !== 32'h1000 + 32'(4*i)) begin errors++; $display("FAIL load_sel%0d: got %h exp %h", i, bus.pc_out, 32'h1000 + 32'(4*i)); end
            checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL load_no_sel_err%0d: got %b exp 0", i, bus.sel_err); end
        end
        for (int s = 6; s < 8; s++) begin
            load(3'(s));
            checks++; if (bus.pc_out !== 32'h1014) begin errors++; $display("FAIL bad_sel%0d_pc: got %h exp 00001014", s, bus.pc_out); end
            checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel%0d_err: got %b exp 1", s, bus.sel_err); end
            tick();
            checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL bad_sel%0d_err_pulse: got %b exp 0", s, bus.sel_err); end
        end
    endtask

    task automatic test_exception();
        set_src(0, 32'h40);
        load(3'd0);
        checks++; if (bus.pc_out !== 32'h40) begin errors++; $display("FAIL exc_setup_pc: got %h exp 00000040", bus.pc_out); end
        bus.exc_req = 1; bus.exc_code = 2'd1;
        tick();
        bus.exc_req = 0;
        checks++; if ({bus.busy, bus.vec_req} !== 2'b10) begin errors++; $display("FAIL exc_save_state: got %b exp 10", {bus.busy, bus.vec_req}); end
        tick();
        checks++; if (bus.epc_out !== 32'h3C) begin errors++; $display("FAIL exc_epc: got %h exp 0000003c", bus.epc_out); end
        for (int w = 0; w < 3; w++) begin
            checks++; if (bus.vec_req !== 1'b1 || bus.vec_addr !== 32'd254) begin errors++; $display("FAIL exc_vec_wait%0d: got req %b addr %0d exp req 1 addr 254", w, bus.vec_req, bus.vec_addr); end
            tick();
        end
        checks++; if (bus.vec_addr !== 32'd254) begin errors++; $display("FAIL exc_vec_addr: got %0d exp 254", bus.vec_addr); end
        bus.vec_ack = 1; bus.vec_data = 8'h7A;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h7A) begin errors++; $display("FAIL exc_handler_pc: got %h exp 0000007a", bus.pc_out); end
        checks++; if ({bus.busy, bus.vec_req} !== 2'b00) begin errors++; $display("FAIL exc_done_flags: got %b exp 00", {bus.busy, bus.vec_req}); end
        set_src(0, 32'h1000);
    endtask

    task automatic test_priority();
        load(3'd2);
        checks++; if (bus.pc_out !== 32'h1008) begin errors++; $display("FAIL prio_setup_pc: got %h exp 00001008", bus.pc_out); end
        bus.exc_req = 1; bus.exc_code = 2'd2; bus.pc_load = 1; bus.sel = 3'd6;
        tick();
        bus.exc_req = 0; bus.sel = 3'd3;
        checks++; if (bus.pc_out !== 32'h1008 || bus.sel_err !== 1'b0) begin errors++; $display("FAIL prio_drop_load: got pc %h err %b exp pc 00001008 err 0", bus.pc_out, bus.sel_err); end
        tick();
        checks++; if (bus.pc_out !== 32'h1008 || bus.epc_out !== 32'h1004) begin errors++; $display("FAIL prio_save: got pc %h epc %h exp 00001008 00001004", bus.pc_out, bus.epc_out); end
        checks++; if (bus.vec_addr !== 32'd255) begin errors++; $display("FAIL prio_vec_addr: got %0d exp 255", bus.vec_addr); end
        bus.sel = 3'd7;
        tick();
        checks++; if (bus.pc_out !== 32'h1008 || bus.sel_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_ignores_load: got pc %h err %b busy %b exp 00001008 0 1", bus.pc_out, bus.sel_err, bus.busy); end
        bus.pc_load = 0; bus.vec_ack = 1; bus.vec_data = 8'h10;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h10) begin errors++; $display("FAIL prio_handler_pc: got %h exp 00000010", bus.pc_out); end
    endtask

    task automatic test_min_latency();
        bus.exc_req = 1; bus.exc_code = 2'd0;
        tick();
        bus.exc_req = 0;
        tick();
        checks++; if (bus.vec_addr !== 32'd253 || bus.epc_out !== 32'h0C) begin errors++; $display("FAIL minlat_fetch: got addr %0d epc %h exp 253 0000000c", bus.vec_addr, bus.epc_out); end
        checks++; if (bus.pc_out !== 32'h10) begin errors++; $display("FAIL minlat_pc_hold: got %h exp 00000010", bus.pc_out); end
        bus.vec_ack = 1; bus.vec_data = 8'h20;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h20 || bus.busy !== 1'b0) begin errors++; $display("FAIL minlat_pc: got pc %h busy %b exp 00000020 0", bus.pc_out, bus.busy); end
    endtask

    task automatic test_vec_ack_idle();
        bus.vec_ack = 1; bus.vec_data = 8'h55;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h20 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got pc %h busy %b exp 00000020 0", bus.pc_out, bus.busy); end
    endtask

    task automatic test_reset_fetch();
        bus.exc_req = 1; bus.exc_code = 2'd3;
        tick();
        bus.exc_req = 0;
        tick();
        checks++; if (bus.vec_req !== 1'b1 || bus.vec_addr !== 32'd256) begin errors++; $display("FAIL code3_vec: got req %b addr %0d exp 1 256", bus.vec_req, bus.vec_addr); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.vec_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_fetch_async: got req %b busy %b exp 0 0", bus.vec_req, bus.busy); end
        checks++; if (bus.pc_out !== 32'h0 || bus.epc_out !== 32'h0) begin errors++; $display("FAIL rst_fetch_regs: got pc %h epc %h exp 0 0", bus.pc_out, bus.epc_out); end
        tick();
        reset = 1'b0;
        bus.vec_ack = 1; bus.vec_data = 8'h99;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got pc %h busy %b exp 0 0", bus.pc_out, bus.busy); end
    endtask

    task automatic test_epc_wrap();
        bus.exc_req = 1; bus.exc_code = 2'd1;
        tick();
        bus.exc_req = 0;
        tick();
        checks++; if (bus.epc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap: got %h exp fffffffc", bus.epc_out); end
        bus.vec_ack = 1; bus.vec_data = 8'h44;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h44) begin errors++; $display("FAIL wrap_handler_pc: got %h exp 00000044", bus.pc_out); end
    endtask

`ifdef PC_SEL_ALIGN_CHECK_EN
    task automatic test_align();
        set_src(0, 32'h1002);
        load(3'd0);
        checks++; if (bus.pc_out !== 32'h44 || bus.align_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL align_reject: got pc %h aerr %b busy %b exp 00000044 1 0", bus.pc_out, bus.align_err, bus.busy); end
        tick();
        checks++; if (bus.align_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL align_pulse: got aerr %b busy %b exp 0 1", bus.align_err, bus.busy); end
        tick();
        checks++; if (bus.vec_addr !== 32'd256 || bus.epc_out !== 32'h40) begin errors++; $display("FAIL align_vec: got addr %0d epc %h exp 256 00000040", bus.vec_addr, bus.epc_out); end
        bus.vec_ack = 1; bus.vec_data = 8'h31;
        tick();
        bus.vec_ack = 0;
        checks++; if (bus.pc_out !== 32'h31 || bus.align_err !== 1'b0) begin errors++; $display("FAIL align_vec_exempt: got pc %h aerr %b exp 00000031 0", bus.pc_out, bus.align_err); end
        set_src(0, 32'h1000);
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_exception();
        test_priority();
        test_min_latency();
        test_vec_ack_idle();
        test_reset_fetch();
        test_epc_wrap();
`ifdef PC_SEL_ALIGN_CHECK_EN
        test_align();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
